inst_sequencer: RTL and testbench



---
 rtl/hypercorex_inst_pkg.sv | 12 +
 rtl/inst_loop_ctr.sv | 48 ++++
 rtl/inst_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_inst_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/hypercorex_inst_pkg.sv
// Shared types for the HDC instruction path: sequencer states and loop-level count.
package hypercorex_inst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } inst_seq_state_e;

    localparam int unsigned INST_SEQ_NUM_LOOPS = 32'd2;

endpackage

// File: rtl/inst_loop_ctr.sv
// One hardware-loop level: iteration counter, back-edge decision and carry to the next level.
// `wrap` is the carry: the step passes through this level without branching.
module inst_loop_ctr #(
    parameter int unsigned AddrWidth    = 7,
    parameter int unsigned LoopCntWidth = 10
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [AddrWidth-1:0]    pc,
    input  logic [AddrWidth-1:0]    start_addr,
    input  logic [AddrWidth-1:0]    end_addr,
    input  logic [LoopCntWidth-1:0] count,
    input  logic                    step,
    input  logic                    clear,
    output logic                    take_branch,
    output logic                    wrap,
    output logic [AddrWidth-1:0]    target
);

    logic [LoopCntWidth-1:0] cnt_r;
    logic [LoopCntWidth:0]   cnt_inc_s;
    logic                    at_end_s;
    logic                    more_s;

    // Extra MSB keeps count = 0 and count = 1 both meaning a single pass.
    assign cnt_inc_s   = {1'b0, cnt_r} + {{LoopCntWidth{1'b0}}, 1'b1};
    assign at_end_s    = (pc == end_addr);
    assign more_s      = (cnt_inc_s < {1'b0, count});
    assign take_branch = step & at_end_s & more_s;
    assign wrap        = step & ~(at_end_s & more_s);
    assign target      = start_addr;

    // Iteration counter: bumps on a taken back-edge, returns to zero when the level exits.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (take_branch) begin
            cnt_r <= cnt_inc_s[LoopCntWidth-1:0];
        end else if (step & at_end_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/inst_sequencer.sv
// Instruction fetch sequencer: walks the PC, fetches from sync imem, presents one word per cycle via a skid slot.
// Hardware loops are built only when INST_SEQ_LOOPS_EN is defined; otherwise the PC runs 0 .. prog_end.
module inst_sequencer
    import hypercorex_inst_pkg::*;
#(
    parameter int unsigned InstWidth    = 32,
    parameter int unsigned InstMemDepth = 128,
    parameter int unsigned LoopCntWidth = 10,
    parameter int unsigned NumLoops     = INST_SEQ_NUM_LOOPS,
    parameter int unsigned AddrWidth    = $clog2(InstMemDepth)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             start_i,
    input  logic                             stop_i,
    input  logic [AddrWidth-1:0]             prog_end_addr_i,
    input  logic [NumLoops*AddrWidth-1:0]    loop_start_addr_i,
    input  logic [NumLoops*AddrWidth-1:0]    loop_end_addr_i,
    input  logic [NumLoops*LoopCntWidth-1:0] loop_count_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             imem_ren_o,
    output logic [AddrWidth-1:0]             imem_addr_o,
    input  logic [InstWidth-1:0]             imem_rdata_i,
    input  logic                             stall_i,
    output logic [InstWidth-1:0]             inst_code_o,
    output logic                             inst_valid_o,
    output logic                             inst_en_o
);

    inst_seq_state_e      state_r, state_n_s;
    logic [AddrWidth-1:0] pc_r, pc_n_s, prog_end_r, branch_pc_s;
    logic                 rvalid_r, skid_full_r;
    logic [InstWidth-1:0] skid_r;
    logic                 start_s, issue_s, at_prog_end_s, take_any_s, fall_s;

    function automatic logic [AddrWidth-1:0] pc_inc(input logic [AddrWidth-1:0] pc);
        if (pc == AddrWidth'(InstMemDepth - 1)) begin
            return '0;
        end else begin
            return pc + AddrWidth'(1);
        end
    endfunction

    // Abort outranks both a new start and a read issue.
    assign start_s       = (state_r == IDLE) & start_i & ~stop_i;
    assign issue_s       = (state_r == RUN) & ~stall_i & ~stop_i;
    assign at_prog_end_s = (pc_r == prog_end_r);

`ifdef INST_SEQ_LOOPS_EN
    logic [NumLoops*AddrWidth-1:0]    loop_start_r, loop_end_r;
    logic [NumLoops*LoopCntWidth-1:0] loop_count_r;
    logic [NumLoops:0]                step_s;
    logic [NumLoops-1:0]              take_s;
    logic [AddrWidth-1:0]             target_s [NumLoops];

    // Loop bounds are captured at start so later CSR writes cannot disturb a running program.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            loop_start_r <= '0;
            loop_end_r   <= '0;
            loop_count_r <= '0;
        end else if (start_s) begin
            loop_start_r <= loop_start_addr_i;
            loop_end_r   <= loop_end_addr_i;
            loop_count_r <= loop_count_i;
        end else begin
            loop_start_r <= loop_start_r;
            loop_end_r   <= loop_end_r;
            loop_count_r <= loop_count_r;
        end
    end

    assign step_s[0] = issue_s;

    for (genvar i = 0; i < NumLoops; i++) begin : g_loop
        inst_loop_ctr #(
            .AddrWidth    (AddrWidth),
            .LoopCntWidth (LoopCntWidth)
        ) u_loop_ctr (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .pc          (pc_r),
            .start_addr  (loop_start_r[i*AddrWidth +: AddrWidth]),
            .end_addr    (loop_end_r[i*AddrWidth +: AddrWidth]),
            .count       (loop_count_r[i*LoopCntWidth +: LoopCntWidth]),
            .step        (step_s[i]),
            .clear       (start_s | stop_i),
            .take_branch (take_s[i]),
            .wrap        (step_s[i+1]),
            .target      (target_s[i])
        );
    end

    // Branch target select; the carry chain lets at most one level branch per issue.
    always_comb begin
        branch_pc_s = '0;
        for (int i = NumLoops - 1; i >= 0; i--) begin
            branch_pc_s = take_s[i] ? target_s[i] : branch_pc_s;
        end
    end

    assign take_any_s = |take_s;
    assign fall_s     = step_s[NumLoops];
`else
    logic loops_unused_s;
    assign loops_unused_s = ^{loop_start_addr_i, loop_end_addr_i, loop_count_i};
    assign branch_pc_s    = '0;
    assign take_any_s     = 1'b0;
    assign fall_s         = issue_s;
`endif

    // Next-PC: loop back-edges first, then stop at the program end, else linear advance.
    always_comb begin
        pc_n_s = pc_r;
        if (start_s) begin
            pc_n_s = '0;
        end else if (take_any_s) begin
            pc_n_s = branch_pc_s;
        end else if (fall_s & ~at_prog_end_s) begin
            pc_n_s = pc_inc(pc_r);
        end else begin
            pc_n_s = pc_r;
        end
    end

    // Sequencer FSM next state.
    always_comb begin
        state_n_s = state_r;
        if (stop_i) begin
            state_n_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_n_s = start_i ? RUN : IDLE;
                RUN:     state_n_s = (fall_s & at_prog_end_s) ? DRAIN : RUN;
                DRAIN:   state_n_s = inst_en_o ? IDLE : DRAIN;
                default: state_n_s = IDLE;
            endcase
        end
    end

    // State, PC, program end and read-valid pipeline.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= IDLE;
            pc_r       <= '0;
            prog_end_r <= '0;
            rvalid_r   <= 1'b0;
        end else begin
            state_r    <= state_n_s;
            pc_r       <= pc_n_s;
            prog_end_r <= start_s ? prog_end_addr_i : prog_end_r;
            rvalid_r   <= issue_s;
        end
    end

    // Skid slot: parks the returning word while the consumer stalls.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            skid_full_r <= 1'b0;
            skid_r      <= '0;
        end else if (start_s | stop_i) begin
            skid_full_r <= 1'b0;
            skid_r      <= '0;
        end else if (rvalid_r & stall_i) begin
            skid_full_r <= 1'b1;
            skid_r      <= imem_rdata_i;
        end else if (skid_full_r & ~stall_i) begin
            skid_full_r <= 1'b0;
            skid_r      <= skid_r;
        end else begin
            skid_full_r <= skid_full_r;
            skid_r      <= skid_r;
        end
    end

    assign busy_o       = (state_r != IDLE);
    assign imem_ren_o   = issue_s;
    assign imem_addr_o  = pc_r;
    assign inst_valid_o = skid_full_r | rvalid_r;
    assign inst_code_o  = skid_full_r ? skid_r : imem_rdata_i;
    assign inst_en_o    = inst_valid_o & ~stall_i;
    assign done_o       = (state_r == DRAIN) & inst_en_o & ~stop_i;

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: linear runs, loops (or their absence), skid under stall, abort and restart.
module tb_inst_sequencer;

    localparam logic [31:0] WBASE = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i, stop_i, stall_i;
    logic [6:0]  prog_end_addr_i;
    logic [13:0] loop_start_addr_i, loop_end_addr_i;
    logic [19:0] loop_count_i;
    logic        busy_o, done_o, imem_ren_o, inst_valid_o, inst_en_o;
    logic [6:0]  imem_addr_o;
    logic [31:0] imem_rdata_i = 32'd0;
    logic [31:0] inst_code_o;

    logic [31:0] log_q [$];
    int          cyc_q [$];
    int          exp_q [$];
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    inst_sequencer dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .start_i           (start_i),
        .stop_i            (stop_i),
        .prog_end_addr_i   (prog_end_addr_i),
        .loop_start_addr_i (loop_start_addr_i),
        .loop_end_addr_i   (loop_end_addr_i),
        .loop_count_i      (loop_count_i),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .imem_ren_o        (imem_ren_o),
        .imem_addr_o       (imem_addr_o),
        .imem_rdata_i      (imem_rdata_i),
        .stall_i           (stall_i),
        .inst_code_o       (inst_code_o),
        .inst_valid_o      (inst_valid_o),
        .inst_en_o         (inst_en_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous instruction memory: word encodes its own address.
    always @(posedge clk) begin
        if (imem_ren_o) imem_rdata_i <= WBASE | 32'(imem_addr_o);
    end

    // Consumption monitor.
    always @(negedge clk) begin
        if (inst_en_o) begin
            log_q.push_back(inst_code_o);
            cyc_q.push_back(cyc);
        end
        if (done_o) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_prog(input string tag, input logic [6:0] pe, input logic [13:0] ls,
                            input logic [13:0] le, input logic [19:0] lc,
                            input int stall_at, input bit mid_start);
        int d0;
        int n;
        int span;
        prog_end_addr_i   = pe;
        loop_start_addr_i = ls;
        loop_end_addr_i   = le;
        loop_count_i      = lc;
        log_q.delete();
        cyc_q.delete();
        d0 = done_cnt;
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        @(negedge clk);
        check_val({tag, "_busy_t1"}, 32'(busy_o), 32'd1);
        check_val({tag, "_ren_t1"}, 32'(imem_ren_o), 32'd1);
        check_val({tag, "_addr_t1"}, 32'(imem_addr_o), 32'd0);
        check_val({tag, "_valid_t1"}, 32'(inst_valid_o), 32'd0);
        if (mid_start) begin
            repeat (2) @(posedge clk);
            #1 start_i = 1'b1;
            @(posedge clk); #1 start_i = 1'b0;
        end
        if (stall_at >= 0) begin
            repeat (stall_at + 1) @(posedge clk);
            #1 stall_i = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check_val({tag, "_skid_code"}, inst_code_o, WBASE | 32'(stall_at));
                check_val({tag, "_skid_en"}, 32'(inst_en_o), 32'd0);
            end
            @(posedge clk); #1 stall_i = 1'b0;
        end
        for (int i = 0; i < 400 && done_cnt == d0; i++) @(posedge clk);
        check_val({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        @(negedge clk);
        check_val({tag, "_busy_after"}, 32'(busy_o), 32'd0);
        n = exp_q.size();
        check_val({tag, "_len"}, 32'(log_q.size()), 32'(n));
        for (int i = 0; i < n && i < log_q.size(); i++) begin
            check_val({tag, "_word"}, log_q[i], WBASE | 32'(exp_q[i]));
        end
        if (log_q.size() > 0) begin
            span = n - 1 + ((stall_at >= 0) ? 3 : 0);
            check_val({tag, "_done_last"}, 32'(done_cyc), 32'(cyc_q[cyc_q.size() - 1]));
            check_val({tag, "_span"}, 32'(cyc_q[cyc_q.size() - 1] - cyc_q[0]), 32'(span));
        end
    endtask

    initial begin
        rst_i = 1'b1;
        start_i = 1'b0;
        stop_i = 1'b0;
        stall_i = 1'b0;
        prog_end_addr_i = 7'd0;
        loop_start_addr_i = 14'd0;
        loop_end_addr_i = 14'd0;
        loop_count_i = 20'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy", 32'(busy_o), 32'd0);
        check_val("rst_done", 32'(done_o), 32'd0);
        check_val("rst_ren", 32'(imem_ren_o), 32'd0);
        check_val("rst_addr", 32'(imem_addr_o), 32'd0);
        check_val("rst_valid", 32'(inst_valid_o), 32'd0);
        check_val("rst_en", 32'(inst_en_o), 32'd0);
        @(posedge clk); #1 rst_i = 1'b0;

        exp_q = '{0, 1, 2, 3};
        run_prog("linear3", 7'd3, 14'd0, 14'd0, 20'd0, -1, 1'b0);

`ifdef INST_SEQ_LOOPS_EN
        exp_q = '{0, 1, 2, 1, 2, 1, 2, 3, 4};
`else
        exp_q = '{0, 1, 2, 3, 4};
`endif
        run_prog("inner", 7'd4, {7'd0, 7'd1}, {7'd0, 7'd2}, {10'd0, 10'd3}, -1, 1'b0);

`ifdef INST_SEQ_LOOPS_EN
        exp_q = '{0, 1, 1, 2, 0, 1, 1, 2};
`else
        exp_q = '{0, 1, 2};
`endif
        run_prog("nested", 7'd2, {7'd0, 7'd1}, {7'd2, 7'd1}, {10'd2, 10'd2}, -1, 1'b0);

        exp_q = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
        run_prog("stall", 7'd8, 14'd0, 14'd0, 20'd0, 5, 1'b0);

        exp_q = '{0, 1, 2, 3, 4, 5};
        run_prog("restart_ign", 7'd5, 14'd0, 14'd0, 20'd0, -1, 1'b1);

        // Abort with a read in flight, then confirm a clean restart.
        begin
            int d0;
            d0 = done_cnt;
            prog_end_addr_i = 7'd20;
            @(posedge clk); #1 start_i = 1'b1;
            @(posedge clk); #1 start_i = 1'b0;
            repeat (2) @(posedge clk);
            #1 stop_i = 1'b1;
            @(negedge clk);
            check_val("stop_inflight", 32'(inst_valid_o), 32'd1);
            @(posedge clk); #1 stop_i = 1'b0;
            @(negedge clk);
            check_val("stop_busy", 32'(busy_o), 32'd0);
            check_val("stop_valid", 32'(inst_valid_o), 32'd0);
            check_val("stop_ren", 32'(imem_ren_o), 32'd0);
            repeat (3) @(negedge clk);
            check_val("stop_no_done", 32'(done_cnt - d0), 32'd0);
        end
        exp_q = '{0, 1, 2};
        run_prog("after_stop", 7'd2, 14'd0, 14'd0, 20'd0, -1, 1'b0);

        @(posedge clk); #1 start_i = 1'b1; stop_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0; stop_i = 1'b0;
        @(negedge clk);
        check_val("startstop_busy", 32'(busy_o), 32'd0);
        check_val("startstop_ren", 32'(imem_ren_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
